// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-timer with load, start/pause, prescaler and DONE pulse.
// Optional BCD_TIMER_AUTORELOAD_EN: restart from the last valid load after 00.
module bcd_down_timer #(
   parameter int PRESCALE = 1
) (
   input  logic       CK,
   input  logic       RN,
   input  logic       LD,
   input  logic [3:0] DZ,
   input  logic [3:0] DU,
   input  logic       ST,
   input  logic       PS,
   output logic [3:0] Qz,
   output logic [3:0] Qu,
   output logic [7:0] Q,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    qz_q, qz_d;
   logic [3:0]    qu_q, qu_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ld_ok, q_zero, q_one, tick;

`ifdef BCD_TIMER_AUTORELOAD_EN
   logic [7:0]    rld_q, rld_d;
`endif

   assign ld_ok  = (DZ <= 4'd9) && (DU <= 4'd9);
   assign q_zero = (qz_q == 4'd0) && (qu_q == 4'd0);
   assign q_one  = (qz_q == 4'd0) && (qu_q == 4'd1);
   assign tick   = (pre_q == PMAX);

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      qz_d    = qz_q;
      qu_d    = qu_q;
      done_d  = 1'b0;
      err_d   = err_q;
`ifdef BCD_TIMER_AUTORELOAD_EN
      rld_d   = rld_q;
`endif
      if (LD) begin
         if (ld_ok) begin
            qz_d    = DZ;
            qu_d    = DU;
            state_d = IDLE;
            pre_d   = '0;
            err_d   = 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            rld_d   = {DZ, DU};
`endif
         end else begin
            err_d = 1'b1;
         end
      end else if (ST && state_q == IDLE && !q_zero) begin
         state_d = RUN;
         pre_d   = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (PS) begin
                  state_d = PAUSE;
               end else if (!tick) begin
                  pre_d = pre_q + 1'b1;
               end else begin
                  pre_d = '0;
                  if (q_one) begin
                     qu_d   = 4'd0;
                     done_d = 1'b1;
`ifndef BCD_TIMER_AUTORELOAD_EN
                     state_d = IDLE;
`endif
`ifdef BCD_TIMER_AUTORELOAD_EN
                  end else if (q_zero) begin
                     qz_d = rld_q[7:4];
                     qu_d = rld_q[3:0];
`endif
                  end else if (qu_q != 4'd0) begin
                     qu_d = qu_q - 4'd1;
                  end else begin
                     qu_d = 4'd9;
                     qz_d = qz_q - 4'd1;
                  end
               end
            end
            PAUSE: begin
               if (!PS) state_d = RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CK) begin
      if (!RN) begin
         state_q <= IDLE;
         pre_q   <= '0;
         qz_q    <= 4'd0;
         qu_q    <= 4'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         qz_q    <= qz_d;
         qu_q    <= qu_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef BCD_TIMER_AUTORELOAD_EN
   always_ff @(posedge CK) begin
      if (!RN) rld_q <= 8'h00;
      else     rld_q <= rld_d;
   end
`endif

   assign Qz   = qz_q;
   assign Qu   = qu_q;
   assign Q    = {qz_q, qu_q};
   assign BUSY = (state_q != IDLE);
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: PRESCALE=1 and PRESCALE=4 instances
// share stimulus; autoreload checks run when BCD_TIMER_AUTORELOAD_EN is set.
module tb_bcd_down_timer;

   logic       CK = 1'b0;
   logic       RN, LD, ST, PS;
   logic [3:0] DZ, DU;
   logic [3:0] qz1, qu1, qz4, qu4;
   logic [7:0] q1, q4;
   logic       busy1, done1, err1, busy4, done4, err4;
   int         total = 0;
   int         bad = 0;

`ifdef BCD_TIMER_AUTORELOAD_EN
   localparam logic AR = 1'b1;
`else
   localparam logic AR = 1'b0;
`endif

   always #5 CK = ~CK;

   bcd_down_timer #(.PRESCALE(1)) u1 (
      .CK(CK), .RN(RN), .LD(LD), .DZ(DZ), .DU(DU), .ST(ST), .PS(PS),
      .Qz(qz1), .Qu(qu1), .Q(q1), .BUSY(busy1), .DONE(done1), .ERR(err1)
   );

   bcd_down_timer #(.PRESCALE(4)) u4 (
      .CK(CK), .RN(RN), .LD(LD), .DZ(DZ), .DU(DU), .ST(ST), .PS(PS),
      .Qz(qz4), .Qu(qu4), .Q(q4), .BUSY(busy4), .DONE(done4), .ERR(err4)
   );

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic idle_in();
      RN = 1'b1; LD = 1'b0; ST = 1'b0; PS = 1'b0;
      DZ = 4'd0; DU = 4'd0;
   endtask

   task automatic load(input logic [3:0] z, input logic [3:0] u);
      LD = 1'b1; DZ = z; DU = u;
      step();
      LD = 1'b0;
   endtask

   task automatic start();
      ST = 1'b1;
      step();
      ST = 1'b0;
   endtask

   initial begin
      idle_in();
      RN = 1'b0;
      step();
      step();
      RN = 1'b1;
      chk("rst_q", q1, 8'h00);
      chk("rst_busy", {7'd0, busy1}, 8'h00);
      chk("rst_err", {7'd0, err1}, 8'h00);

      // countdown 03 -> 00
      load(4'd0, 4'd3);
      chk("ld03", q1, 8'h03);
      start();
      chk("st_busy", {7'd0, busy1}, 8'h01);
      chk("st_hold", q1, 8'h03);
      step();
      chk("cd02", q1, 8'h02);
      chk("cd02_done", {7'd0, done1}, 8'h00);
      step();
      chk("cd01", q1, 8'h01);
      step();
      chk("cd00", q1, 8'h00);
      chk("cd00_done", {7'd0, done1}, 8'h01);
      chk("cd00_busy", {7'd0, busy1}, {7'd0, AR});
      step();
      chk("post_done", {7'd0, done1}, 8'h00);

      // borrow
      load(4'd2, 4'd0);
      start();
      step();
      chk("brw19", q1, 8'h19);

      // 10 -> 09, prescale 4 on u4
      load(4'd1, 4'd0);
      start();
      step();
      chk("p1_09", q1, 8'h09);
      step();
      step();
      chk("p4_hold", q4, 8'h10);
      step();
      chk("p4_09", q4, 8'h09);
      repeat (4) step();
      chk("p4_08", q4, 8'h08);
      chk("p1_02", q1, 8'h02);

      // invalid load mid-run holds everything
      load(4'hA, 4'd5);
      chk("inv_err", {7'd0, err1}, 8'h01);
      chk("inv_q", q1, 8'h02);
      chk("inv_busy", {7'd0, busy1}, 8'h01);
      chk("inv_q4", q4, 8'h08);
      step();
      chk("inv_cont", q1, 8'h01);
      load(4'd4, 4'd5);
      chk("ok_err", {7'd0, err1}, 8'h00);
      chk("ok_q", q1, 8'h45);
      chk("ok_busy", {7'd0, busy1}, 8'h00);

      // pause / override
      load(4'd1, 4'd0);
      start();
      PS = 1'b1;
      repeat (5) step();
      chk("ps_q", q1, 8'h10);
      chk("ps_busy", {7'd0, busy1}, 8'h01);
      PS = 1'b0;
      step();
      chk("rs_q", q1, 8'h10);
      step();
      chk("rs_09", q1, 8'h09);
      load(4'd5, 4'd0);
      chk("ovr_q", q1, 8'h50);
      chk("ovr_busy", {7'd0, busy1}, 8'h00);
      load(4'd0, 4'd0);
      start();
      chk("st00_busy", {7'd0, busy1}, 8'h00);
      chk("st00_q", q1, 8'h00);
      chk("st00_done", {7'd0, done1}, 8'h00);

      // reset mid-run clears sticky error
      load(4'd0, 4'd5);
      start();
      step();
      load(4'hF, 4'hF);
      chk("pre_rst_err", {7'd0, err1}, 8'h01);
      RN = 1'b0;
      step();
      RN = 1'b1;
      chk("mr_q", q1, 8'h00);
      chk("mr_busy", {7'd0, busy1}, 8'h00);
      chk("mr_done", {7'd0, done1}, 8'h00);
      chk("mr_err", {7'd0, err1}, 8'h00);

`ifdef BCD_TIMER_AUTORELOAD_EN
      load(4'd0, 4'd2);
      start();
      step();
      chk("ar01", q1, 8'h01);
      step();
      chk("ar00", q1, 8'h00);
      chk("ar00_done", {7'd0, done1}, 8'h01);
      step();
      chk("ar02", q1, 8'h02);
      chk("ar02_done", {7'd0, done1}, 8'h00);
      step();
      chk("ar01b", q1, 8'h01);
      step();
      chk("ar00b", q1, 8'h00);
      chk("ar00b_done", {7'd0, done1}, 8'h01);
      step();
      chk("ar02b", q1, 8'h02);
      chk("ar_busy", {7'd0, busy1}, 8'h01);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
